axis2mat_pixel_unpack: RTL

- Dataflow consumer stage directly downstream of the 1-bit start-token FIFO that launches the AXI-stream-to-Mat conversion.
- Pops one start token per frame and samples the frame geometry.
- Accepts AXI4-Stream words and unpacks each into PPW = AXI_WIDTH/PIX_WIDTH pixels.
- Writes pixels one per cycle into the downstream Mat pixel FIFO, then signals frame completion.

---
 rtl/axis2mat_pixel_unpack.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/axis2mat_pixel_unpack.sv
// -----------------------------------------------------------------------------
// axis2mat_pixel_unpack
//
// Consumer stage of the AXI-stream-to-Mat conversion. It pops one start token
// per frame and freezes the frame geometry (rows*cols). It then accepts
// AXI4-Stream words and writes their PPW = AXI_WIDTH/PIX_WIDTH pixels one per
// cycle into the Mat pixel FIFO. Pixels beyond the frame end in the final word
// are dropped. A one-cycle ap_done pulse marks the end of the frame.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start_empty_n       start-token FIFO holds a token
//   start_read          pop the start-token FIFO (combinational, IDLE only)
//   rows, cols          frame geometry, sampled on the token pop
//   s_axis_tdata/tvalid/tlast/tready   input stream (tlast only for checking)
//   out_din, out_full_n, out_write     Mat pixel FIFO write side
//   ap_idle             high while waiting for a start token
//   ap_done             one-cycle pulse at frame end
//   err_tlast           sticky TLAST mismatch flag
//
// Configuration:
//   AXIS2MAT_TLAST_CHECK_EN  when defined, each accepted beat compares tlast
//                            against "this is the final word of the frame" and
//                            sets err_tlast on a mismatch. When undefined,
//                            err_tlast is tied low and tlast is ignored.
// -----------------------------------------------------------------------------
module axis2mat_pixel_unpack #(
  parameter int AXI_WIDTH = 64,
  parameter int PIX_WIDTH = 8,
  parameter int DIM_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_empty_n,
  output logic                 start_read,
  input  logic [DIM_WIDTH-1:0] rows,
  input  logic [DIM_WIDTH-1:0] cols,
  input  logic [AXI_WIDTH-1:0] s_axis_tdata,
  input  logic                 s_axis_tvalid,
  input  logic                 s_axis_tlast,
  output logic                 s_axis_tready,
  output logic [PIX_WIDTH-1:0] out_din,
  input  logic                 out_full_n,
  output logic                 out_write,
  output logic                 ap_idle,
  output logic                 ap_done,
  output logic                 err_tlast
);

  localparam int PPW    = AXI_WIDTH / PIX_WIDTH;
  localparam int LANE_W = $clog2(PPW + 1);
  localparam int REM_W  = 2 * DIM_WIDTH;
  localparam logic [REM_W-1:0] PPW_R = REM_W'(PPW);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    EMIT,
    DONE
  } state_t;

  state_t               state, state_nxt;
  logic [REM_W-1:0]     remaining, remaining_nxt;
  logic [LANE_W-1:0]    lanes, lanes_nxt;
  logic [AXI_WIDTH-1:0] unpack_reg, unpack_nxt;
  logic [REM_W-1:0]     frame_pixels;
  logic [LANE_W-1:0]    fetch_lanes;
  logic                 beat_accept;

  // Full-width product so large frames never wrap.
  assign frame_pixels = REM_W'(rows) * REM_W'(cols);

  // Lanes that carry real pixels in the word being fetched: min(PPW, remaining).
  assign fetch_lanes = (remaining < PPW_R) ? LANE_W'(remaining) : LANE_W'(PPW);

  assign beat_accept = s_axis_tready & s_axis_tvalid;

  // Lane 0 is presented straight from the register, so it is stable while the
  // Mat FIFO is full.
  assign out_din = reset ? '0 : unpack_reg[PIX_WIDTH-1:0];
  assign ap_idle = reset | (state == IDLE);

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_nxt     = state;
    remaining_nxt = remaining;
    lanes_nxt     = lanes;
    unpack_nxt    = unpack_reg;
    start_read    = 1'b0;
    s_axis_tready = 1'b0;
    out_write     = 1'b0;
    ap_done       = 1'b0;

    unique case (state)
      IDLE: begin
        if (start_empty_n) begin
          start_read    = 1'b1;
          remaining_nxt = frame_pixels;
          state_nxt     = (frame_pixels == '0) ? DONE : FETCH;
        end
      end

      FETCH: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid) begin
          unpack_nxt = s_axis_tdata;
          lanes_nxt  = fetch_lanes;
          state_nxt  = EMIT;
        end
      end

      EMIT: begin
        out_write = out_full_n;
        if (out_full_n) begin
          unpack_nxt    = unpack_reg >> PIX_WIDTH;
          lanes_nxt     = lanes - LANE_W'(1);
          remaining_nxt = remaining - REM_W'(1);
          // Leftover lanes of a partial final word are simply never emitted.
          if (lanes == LANE_W'(1)) begin
            state_nxt = (remaining == REM_W'(1)) ? DONE : FETCH;
          end
        end
      end

      DONE: begin
        ap_done   = 1'b1;
        state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase

    // No handshake or completion is visible in the reset cycle.
    if (reset) begin
      start_read    = 1'b0;
      s_axis_tready = 1'b0;
      out_write     = 1'b0;
      ap_done       = 1'b0;
    end
  end

  // NOTE: reset here is synchronous and active-high, so it sits inside the
  // clocked branch rather than in the sensitivity list.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      remaining  <= '0;
      lanes      <= '0;
      // NOTE: the unpack register is a data register but is cleared anyway,
      // since out_din is driven straight from it and must read 0 after reset.
      unpack_reg <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values.
      state      <= state_nxt;
      remaining  <= remaining_nxt;
      lanes      <= lanes_nxt;
      unpack_reg <= unpack_nxt;
    end
  end

`ifdef AXIS2MAT_TLAST_CHECK_EN
  // A beat is the frame's final word when it covers all remaining pixels.
  logic beat_final;
  assign beat_final = (remaining <= PPW_R);

  always_ff @(posedge clk) begin
    if (reset) begin
      err_tlast <= 1'b0;
    end else if (beat_accept && (s_axis_tlast != beat_final)) begin
      err_tlast <= 1'b1;
    end
  end
`else
  logic unused_tlast;
  assign unused_tlast = s_axis_tlast ^ beat_accept;
  assign err_tlast    = 1'b0;
`endif

endmodule
